multicycle_control_unit: RTL and testbench

//   Multi-cycle FSM controller for the 16-bit-instruction / 8-bit-data core.

---
 rtl/cpu_defs.sv | 54 +++++
 rtl/multicycle_control_unit_if.sv | 17 +
 rtl/mem_timeout_counter.sv | 37 +++
 rtl/multicycle_control_unit.sv | 187 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_defs.sv
// Shared definitions for the 16-bit-instruction / 8-bit-data core.
// Holds the opcode map, the datapath select codes used by the controller and
// the immediate generator, and the controller state type.
package cpu_defs;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_SHL   = 4'h5;
    localparam logic [3:0] OP_SHR   = 4'h6;
    localparam logic [3:0] OP_ADDI  = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_LDI   = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_BNE   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] IMM_SRC_LDI_JMP = 2'b00;
    localparam logic [1:0] IMM_SRC_MEM_BR  = 2'b01;
    localparam logic [1:0] IMM_SRC_SHIFT   = 2'b10;
    localparam logic [1:0] IMM_SRC_ADDI    = 2'b11;

    localparam logic [2:0] ALU_OP_ADD    = 3'b000;
    localparam logic [2:0] ALU_OP_SUB    = 3'b001;
    localparam logic [2:0] ALU_OP_AND    = 3'b010;
    localparam logic [2:0] ALU_OP_OR     = 3'b011;
    localparam logic [2:0] ALU_OP_XOR    = 3'b100;
    localparam logic [2:0] ALU_OP_SHL    = 3'b101;
    localparam logic [2:0] ALU_OP_SHR    = 3'b110;
    localparam logic [2:0] ALU_OP_PASS_B = 3'b111;

    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_IMM = 2'b10;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_HALT
    } state_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Shared memory port between the controller and memory.
//   instr      read data (instruction word during FETCH)
//   mem_ready  memory completes the access this cycle
//   mem_req    access request
//   mem_we     write access
//   addr_sel   address source: 0 = PC, 1 = ALU result
// master = controller side, slave = memory side.
interface multicycle_control_unit_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;

    modport master (input instr, mem_ready, output mem_req, mem_we, addr_sel);
    modport slave  (output instr, mem_ready, input mem_req, mem_we, addr_sel);
endinterface

// File: rtl/mem_timeout_counter.sv
// Counts consecutive cycles a memory request waits for ready.
//   clk, rst_n  clock, async active-low reset
//   req, ready  request and completion of the current access
//   expired     count has reached TIMEOUT_CYCLES (never when TIMEOUT_CYCLES = 0)
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ready,
    output logic expired
);
    localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic unused_off;
            assign unused_off = clk ^ rst_n ^ req ^ ready;
            assign expired    = 1'b0;
        end else begin : g_on
            logic [W-1:0] count;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count <= '0;
                end else if (req && ready) begin
                    count <= '0;
                end else if (req && !expired) begin
                    count <= count + 1'b1;
                end
            end

            assign expired = (count == W'(TIMEOUT_CYCLES));
        end
    endgenerate
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle FSM controller: sequences fetch, decode, execute, memory and
// writeback over a shared memory port, and drives all datapath strobes.
//   clk, rst_n     clock, async active-low reset
//   bus            memory port (instr, mem_ready in; mem_req, mem_we, addr_sel out)
//   zero           ALU zero flag, sampled in EXECUTE
//   ir_write, pc_write, pc_src, imm_src, alu_op, alu_src_b, reg_write, wb_sel
//                  datapath strobes
//   instr_retired  pulse on the last cycle of each instruction
//   halted         FSM is in HALT
//   bus_err        sticky memory-timeout flag
module multicycle_control_unit
    import cpu_defs::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_unit_if.master   bus,
    input  logic                        zero,
    output logic                        ir_write,
    output logic                        pc_write,
    output logic [1:0]                  pc_src,
    output logic [1:0]                  imm_src,
    output logic [2:0]                  alu_op,
    output logic                        alu_src_b,
    output logic                        reg_write,
    output logic [1:0]                  wb_sel,
    output logic                        instr_retired,
    output logic                        halted,
    output logic                        bus_err
);
    state_t     state, next_state;
    logic [3:0] opcode;
    logic       active;
    logic       bus_err_q;
    logic       expired;
    logic       mem_req, mem_we, addr_sel;
    logic       unused_instr;

    assign unused_instr = ^bus.instr[11:0];

    // active keeps every strobe low through reset and until the first clock
    // after release, so mem_req does not rise combinationally with rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            opcode    <= OP_NOP;
            active    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            active <= 1'b1;
            state  <= next_state;
            if (ir_write) opcode <= bus.instr[15:12];
            if (expired)  bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        next_state    = state;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_INC;
        imm_src       = IMM_SRC_LDI_JMP;
        alu_op        = ALU_OP_ADD;
        alu_src_b     = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_SEL_ALU;
        instr_retired = 1'b0;

        if (!active) begin
            next_state = state;
        end else if (expired) begin
            next_state = ST_HALT;
        end else begin
            unique case (state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        pc_src     = PC_SRC_INC;
                        next_state = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    case (opcode)
                        OP_JMP: begin
                            pc_write      = 1'b1;
                            pc_src        = PC_SRC_JUMP;
                            imm_src       = IMM_SRC_LDI_JMP;
                            instr_retired = 1'b1;
                            next_state    = ST_FETCH;
                        end
                        OP_NOP: begin
                            instr_retired = 1'b1;
                            next_state    = ST_FETCH;
                        end
                        OP_HALT: begin
                            instr_retired = 1'b1;
                            next_state    = ST_HALT;
                        end
                        OP_LDI:  next_state = ST_WRITEBACK;
                        default: next_state = ST_EXECUTE;
                    endcase
                end
                ST_EXECUTE: begin
                    next_state = ST_WRITEBACK;
                    case (opcode)
                        OP_ADD: alu_op = ALU_OP_ADD;
                        OP_SUB: alu_op = ALU_OP_SUB;
                        OP_AND: alu_op = ALU_OP_AND;
                        OP_OR:  alu_op = ALU_OP_OR;
                        OP_XOR: alu_op = ALU_OP_XOR;
                        OP_SHL, OP_SHR: begin
                            alu_op    = (opcode == OP_SHL) ? ALU_OP_SHL : ALU_OP_SHR;
                            alu_src_b = 1'b1;
                            imm_src   = IMM_SRC_SHIFT;
                        end
                        OP_ADDI: begin
                            alu_op    = ALU_OP_ADD;
                            alu_src_b = 1'b1;
                            imm_src   = IMM_SRC_ADDI;
                        end
                        OP_LOAD, OP_STORE: begin
                            alu_op     = ALU_OP_ADD;
                            alu_src_b  = 1'b1;
                            imm_src    = IMM_SRC_MEM_BR;
                            next_state = ST_MEMORY;
                        end
                        OP_BEQ, OP_BNE: begin
                            alu_op  = ALU_OP_SUB;
                            imm_src = IMM_SRC_MEM_BR;
                            if ((opcode == OP_BEQ) ? zero : !zero) begin
                                pc_write = 1'b1;
                                pc_src   = PC_SRC_BRANCH;
                            end
                            instr_retired = 1'b1;
                            next_state    = ST_FETCH;
                        end
                        default: next_state = ST_FETCH;
                    endcase
                end
                ST_MEMORY: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mem_we   = (opcode == OP_STORE);
                    if (bus.mem_ready) begin
                        if (opcode == OP_STORE) begin
                            instr_retired = 1'b1;
                            next_state    = ST_FETCH;
                        end else begin
                            next_state = ST_WRITEBACK;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    reg_write     = 1'b1;
                    wb_sel        = (opcode == OP_LOAD) ? WB_SEL_MEM :
                                    (opcode == OP_LDI)  ? WB_SEL_IMM : WB_SEL_ALU;
                    instr_retired = 1'b1;
                    next_state    = ST_FETCH;
                end
                ST_HALT: next_state = ST_HALT;
                default: next_state = ST_FETCH;
            endcase
        end
    end

    // The counter watches the gated mem_req; expired depends only on its
    // registered count, so there is no combinational loop through mem_req.
    mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (mem_req),
        .ready   (bus.mem_ready),
        .expired (expired)
    );

    assign bus.mem_req  = mem_req;
    assign bus.mem_we   = mem_we;
    assign bus.addr_sel = addr_sel;
    assign halted       = (state == ST_HALT);
    assign bus_err      = bus_err_q | expired;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit. A per-instruction model
// expands each opcode into its expected cycle-by-cycle strobe trace.
module tb_multicycle_control_unit;
    import cpu_defs::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic [1:0] imm_src;
        logic [2:0] alu_op;
        logic       alu_src_b;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       retired;
        logic       halted;
        logic       bus_err;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  ready;
        logic  zero;
        logic  fetch;
    } cyc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic zero = 1'b0;
    logic zero_t = 1'b0;
    always #5 clk = ~clk;

    logic       ir_write, pc_write, alu_src_b, reg_write, instr_retired, halted, bus_err;
    logic [1:0] pc_src, imm_src, wb_sel;
    logic [2:0] alu_op;
    logic       ir_write_t, pc_write_t, alu_src_b_t, reg_write_t, instr_retired_t, halted_t, bus_err_t;
    logic [1:0] pc_src_t, imm_src_t, wb_sel_t;
    logic [2:0] alu_op_t;

    multicycle_control_unit_if bus ();
    multicycle_control_unit_if bus_t ();

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .zero(zero),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .imm_src(imm_src),
        .alu_op(alu_op), .alu_src_b(alu_src_b), .reg_write(reg_write), .wb_sel(wb_sel),
        .instr_retired(instr_retired), .halted(halted), .bus_err(bus_err)
    );

    multicycle_control_unit #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk(clk), .rst_n(rst_n), .bus(bus_t), .zero(zero_t),
        .ir_write(ir_write_t), .pc_write(pc_write_t), .pc_src(pc_src_t), .imm_src(imm_src_t),
        .alu_op(alu_op_t), .alu_src_b(alu_src_b_t), .reg_write(reg_write_t), .wb_sel(wb_sel_t),
        .instr_retired(instr_retired_t), .halted(halted_t), .bus_err(bus_err_t)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    cyc_t exp_q[$];

    function automatic outs_t obs();
        outs_t r;
        r = {bus.mem_req, bus.mem_we, bus.addr_sel, ir_write, pc_write, pc_src, imm_src,
             alu_op, alu_src_b, reg_write, wb_sel, instr_retired, halted, bus_err};
        return r;
    endfunction

    function automatic outs_t obs_t();
        outs_t r;
        r = {bus_t.mem_req, bus_t.mem_we, bus_t.addr_sel, ir_write_t, pc_write_t, pc_src_t,
             imm_src_t, alu_op_t, alu_src_b_t, reg_write_t, wb_sel_t, instr_retired_t,
             halted_t, bus_err_t};
        return r;
    endfunction

    // mem_ready is only meaningful while a request is expected; otherwise it
    // is randomised to show it is ignored. zero likewise outside EXECUTE.
    function automatic void push(input outs_t o, input logic rdy, input logic zf_valid,
                                 input logic zf, input logic fe);
        cyc_t c;
        c.o     = o;
        c.ready = o.mem_req ? rdy : 1'($urandom);
        c.zero  = zf_valid ? zf : 1'($urandom);
        c.fetch = fe;
        exp_q.push_back(c);
    endfunction

    function automatic void build_expected(input logic [3:0] op, input logic z,
                                           input int unsigned fw, input int unsigned mw);
        outs_t o;
        logic  taken;
        for (int unsigned i = 0; i < fw; i++) begin
            o = '0; o.mem_req = 1'b1;
            push(o, 1'b0, 1'b0, 1'b0, 1'b1);
        end
        o = '0; o.mem_req = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        push(o, 1'b1, 1'b0, 1'b0, 1'b1);
        // decode
        o = '0;
        if (op == 4'hD) begin
            o.pc_write = 1'b1; o.pc_src = 2'b10; o.retired = 1'b1;
            push(o, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        if (op == 4'hE || op == 4'hF) begin
            o.retired = 1'b1;
            push(o, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        push(o, 1'b0, 1'b0, 1'b0, 1'b0);
        if (op != 4'hA) begin
            o = '0;
            case (op)
                4'h0: o.alu_op = 3'b000;
                4'h1: o.alu_op = 3'b001;
                4'h2: o.alu_op = 3'b010;
                4'h3: o.alu_op = 3'b011;
                4'h4: o.alu_op = 3'b100;
                4'h5: begin o.alu_op = 3'b101; o.alu_src_b = 1'b1; o.imm_src = 2'b10; end
                4'h6: begin o.alu_op = 3'b110; o.alu_src_b = 1'b1; o.imm_src = 2'b10; end
                4'h7: begin o.alu_op = 3'b000; o.alu_src_b = 1'b1; o.imm_src = 2'b11; end
                4'h8, 4'h9: begin o.alu_src_b = 1'b1; o.imm_src = 2'b01; end
                default: begin
                    taken = (op == 4'hB) ? z : !z;
                    o.alu_op = 3'b001; o.imm_src = 2'b01; o.retired = 1'b1;
                    if (taken) begin o.pc_write = 1'b1; o.pc_src = 2'b01; end
                    push(o, 1'b0, 1'b1, z, 1'b0);
                    return;
                end
            endcase
            push(o, 1'b0, 1'b1, z, 1'b0);
            if (op == 4'h8 || op == 4'h9) begin
                o = '0; o.mem_req = 1'b1; o.addr_sel = 1'b1; o.mem_we = (op == 4'h9);
                for (int unsigned i = 0; i < mw; i++) push(o, 1'b0, 1'b0, 1'b0, 1'b0);
                o.retired = (op == 4'h9);
                push(o, 1'b1, 1'b0, 1'b0, 1'b0);
                if (op == 4'h9) return;
            end
        end
        o = '0; o.reg_write = 1'b1; o.retired = 1'b1;
        o.wb_sel = (op == 4'h8) ? 2'b01 : (op == 4'hA) ? 2'b10 : 2'b00;
        push(o, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic drive_cycle(input cyc_t c, input logic [15:0] iw, output outs_t got);
        @(negedge clk);
        bus.mem_ready = c.ready;
        zero          = c.zero;
        bus.instr     = c.fetch ? iw : 16'($urandom);
        #1;
        got = obs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        outs_t got;
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.instr     = 16'h0123;
        #1;
        rst_n = 1'b0;
        #1;
        got = obs();
        n_cmp++;
        if (got !== outs_t'('0)) begin
            n_bad++; $display("FAIL reset_async got %h expected %h", got, outs_t'('0));
        end
        got = obs_t();
        n_cmp++;
        if (got !== outs_t'('0)) begin
            n_bad++; $display("FAIL reset_async_t got %h expected %h", got, outs_t'('0));
        end
        @(posedge clk); #1;
        got = obs();
        n_cmp++;
        if (got !== outs_t'('0)) begin
            n_bad++; $display("FAIL reset_held got %h expected %h", got, outs_t'('0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin
            n_bad++; $display("FAIL reset_release_req got %b expected 0", bus.mem_req);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.mem_req !== 1'b1 || bus.addr_sel !== 1'b0) begin
            n_bad++; $display("FAIL reset_first_fetch got req=%b sel=%b expected req=1 sel=0",
                              bus.mem_req, bus.addr_sel);
        end
    endtask

    task automatic test_directed();
        string       nm[6]  = '{"add", "load_wait", "beq_taken", "bne_not_taken", "jmp", "ldi"};
        logic [15:0] iw[6]  = '{16'h0123, 16'h8456, 16'hB123, 16'hC123, 16'hD2A0, 16'hA05C};
        logic        zv[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        int unsigned mw[6]  = '{0, 3, 0, 0, 0, 0};
        logic [3:0]  op;
        outs_t       got;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            exp_q.delete();
            op = iw[i][15:12];
            build_expected(op, zv[i], 0, mw[i]);
            for (int k = 0; k < exp_q.size(); k++) begin
                drive_cycle(exp_q[k], iw[i], got);
                n_cmp++;
                if (got !== exp_q[k].o) begin
                    n_bad++;
                    $display("FAIL %s cycle %0d got %h expected %h", nm[i], k + 1, got, exp_q[k].o);
                end
            end
        end
    endtask

    task automatic test_halt();
        outs_t got, e;
        cyc_t  c;
        do_reset();
        exp_q.delete();
        build_expected(4'hF, 1'b0, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive_cycle(exp_q[k], 16'hF000, got);
            n_cmp++;
            if (got !== exp_q[k].o) begin
                n_bad++; $display("FAIL halt_instr cycle %0d got %h expected %h", k + 1, got, exp_q[k].o);
            end
        end
        e = '0; e.halted = 1'b1;
        for (int k = 0; k < 6; k++) begin
            c.o = e; c.ready = 1'($urandom); c.zero = 1'($urandom); c.fetch = 1'b1;
            drive_cycle(c, 16'h0123, got);
            n_cmp++;
            if (got !== e) begin
                n_bad++; $display("FAIL halt_hold cycle %0d got %h expected %h", k + 1, got, e);
            end
        end
    endtask

    task automatic test_timeout();
        outs_t got, e;
        do_reset();
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            bus_t.instr = 16'($urandom);
            #1;
            got = obs_t();
            e = '0;
            if (cyc <= 4) e.mem_req = 1'b1;
            else if (cyc == 5) e.bus_err = 1'b1;
            else begin e.bus_err = 1'b1; e.halted = 1'b1; end
            n_cmp++;
            if (got !== e) begin
                n_bad++; $display("FAIL timeout cycle %0d got %h expected %h", cyc, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        outs_t got;
        do_reset();
        exp_q.delete();
        build_expected(4'h9, 1'b0, 0, 5);
        for (int k = 0; k < 4; k++) begin
            drive_cycle(exp_q[k], 16'h9321, got);
            n_cmp++;
            if (got !== exp_q[k].o) begin
                n_bad++; $display("FAIL store_pre cycle %0d got %h expected %h", k + 1, got, exp_q[k].o);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = obs();
        n_cmp++;
        if (got !== outs_t'('0)) begin
            n_bad++; $display("FAIL store_reset_drop got %h expected %h", got, outs_t'('0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        build_expected(4'hE, 1'b0, 0, 0);
        for (int k = 0; k < exp_q.size(); k++) begin
            drive_cycle(exp_q[k], 16'hE000, got);
            n_cmp++;
            if (got !== exp_q[k].o) begin
                n_bad++; $display("FAIL store_after_reset cycle %0d got %h expected %h", k + 1, got, exp_q[k].o);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [15:0] iw;
        outs_t       got;
        do_reset();
        for (int n = 0; n < 60; n++) begin
            op = 4'($urandom_range(0, 14));
            iw = {op, 12'($urandom)};
            exp_q.delete();
            build_expected(op, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
            for (int k = 0; k < exp_q.size(); k++) begin
                drive_cycle(exp_q[k], iw, got);
                n_cmp++;
                if (got !== exp_q[k].o) begin
                    n_bad++;
                    $display("FAIL random instr %0d op %h cycle %0d got %h expected %h",
                             n, op, k + 1, got, exp_q[k].o);
                end
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr       = 16'hE000;
        bus.mem_ready   = 1'b0;
        bus_t.instr     = 16'h0000;
        bus_t.mem_ready = 1'b0;
        test_reset();
        test_directed();
        test_halt();
        test_timeout();
        test_reset_mid_store();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
